// File: rtl/alu_div_if.sv
// Request/response bundle between the core pipeline and the RV32M divide unit.
// The master issues start/op/operands; the slave returns busy/done/result.
interface alu_div_if #(
    parameter int n = 32
);
    logic         start_in;
    logic [1:0]   op_in;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [n-1:0] ALUResult;

    modport master (
        output start_in, op_in, A, B,
        input  busy, done, div_by_zero, ALUResult
    );

    modport slave (
        input  start_in, op_in, A, B,
        output busy, done, div_by_zero, ALUResult
    );
endinterface

// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro ALU_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC.
module alu_div_unit #(
    parameter int n = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_div_if.slave   bus
);
    localparam int CW = $clog2(n);
    localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [n-1:0]  rem_reg, quo_reg, div_reg, a_raw_reg;
    logic [1:0]    op_reg;
    logic          q_neg_reg, r_neg_reg, dbz_reg, ovf_reg;
    logic [n-1:0]  result_reg;
    logic          dbz_out_reg;

    logic          accept;
    logic          in_signed, in_dbz, in_ovf, fast_special;
    logic [n-1:0]  a_abs, b_abs;
    logic [n:0]    trial;
    logic [n-1:0]  rem_step, quo_step, quo_fix, rem_fix, final_value;
    logic          last_iter;

    // Results forced for B==0 and signed overflow, regardless of iteration output.
    function automatic logic [n-1:0] special_value(input logic [1:0] op,
                                                   input logic [n-1:0] a,
                                                   input logic dbz);
        if (dbz)
            return op[1] ? a : '1;
        else
            return op[1] ? '0 : MIN_NEG;
    endfunction

    assign accept    = (state_reg == IDLE) && bus.start_in;
    assign in_signed = ~bus.op_in[0];
    assign in_dbz    = (bus.B == '0);
    assign in_ovf    = in_signed && (bus.A == MIN_NEG) && (bus.B == '1);
    assign a_abs     = (in_signed && bus.A[n-1]) ? -bus.A : bus.A;
    assign b_abs     = (in_signed && bus.B[n-1]) ? -bus.B : bus.B;

`ifdef ALU_DIV_FAST_SPECIAL_EN
    assign fast_special = in_dbz | in_ovf;
`else
    assign fast_special = 1'b0;
`endif

    // Shifted partial remainder is n+1 bits; a clear top bit of the trial means "fits".
    assign trial     = {rem_reg, quo_reg[n-1]} - {1'b0, div_reg};
    assign rem_step  = trial[n] ? {rem_reg[n-2:0], quo_reg[n-1]} : trial[n-1:0];
    assign quo_step  = {quo_reg[n-2:0], ~trial[n]};
    assign last_iter = (state_reg == CALC) && (count_reg == '0);

    assign quo_fix     = q_neg_reg ? -quo_step : quo_step;
    assign rem_fix     = r_neg_reg ? -rem_step : rem_step;
    assign final_value = (dbz_reg || ovf_reg) ? special_value(op_reg, a_raw_reg, dbz_reg)
                                              : (op_reg[1] ? rem_fix : quo_fix);

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.start_in) state_next = fast_special ? DONE : CALC;
            CALC:    if (count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            div_reg     <= '0;
            a_raw_reg   <= '0;
            op_reg      <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            dbz_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            result_reg  <= '0;
            dbz_out_reg <= 1'b0;
        end else if (accept) begin
            count_reg <= CW'(n - 1);
            rem_reg   <= '0;
            quo_reg   <= a_abs;
            div_reg   <= b_abs;
            a_raw_reg <= bus.A;
            op_reg    <= bus.op_in;
            q_neg_reg <= in_signed && (bus.A[n-1] ^ bus.B[n-1]);
            r_neg_reg <= in_signed && bus.A[n-1];
            dbz_reg   <= in_dbz;
            ovf_reg   <= in_ovf;
            if (fast_special) begin
                result_reg  <= special_value(bus.op_in, bus.A, in_dbz);
                dbz_out_reg <= in_dbz;
            end
        end else if (state_reg == CALC) begin
            rem_reg   <= rem_step;
            quo_reg   <= quo_step;
            count_reg <= count_reg - CW'(1);
            // Visible outputs change only at DONE entry; they hold through the next CALC.
            if (last_iter) begin
                result_reg  <= final_value;
                dbz_out_reg <= dbz_reg;
            end
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.div_by_zero = dbz_out_reg;
    assign bus.ALUResult   = result_reg;
endmodule

// File: tb/tb_alu_div_unit.sv
// Scoreboard bench for alu_div_unit: driver pushes model results, negedge monitor checks
// done/result/latency, busy window and output holding.
module tb_alu_div_unit;
    localparam int N = 32;
    localparam logic [N-1:0] MIN = 32'h8000_0000;

`ifdef ALU_DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] res;
        logic         dbz;
        int           cyc;
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    logic [N-1:0] held_res = '0;
    logic         held_dbz = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    logic exp_busy;

    alu_div_if #(.n(N)) bus();

    alu_div_unit #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain RV32M semantics using the simulator's own arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [N-1:0] a,
                                      input logic [N-1:0] b,
                                      output logic [N-1:0] r, output logic dbz);
        dbz = (b == '0);
        if (dbz) begin
            r = op[1] ? a : '1;
        end else begin
            case (op)
                2'd0:    r = (a == MIN && b == '1) ? MIN : N'($signed(a) / $signed(b));
                2'd1:    r = a / b;
                2'd2:    r = (a == MIN && b == '1) ? '0 : N'($signed(a) % $signed(b));
                default: r = a % b;
            endcase
        end
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [N-1:0] a,
                                      input logic [N-1:0] b);
        return (b == '0) || (!op[0] && a == MIN && b == '1);
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) @(posedge clk) #1;
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout cyc=%0d busy got 1 want 0", cyc);
        end
    endtask

    // Called at posedge+1; the acceptance edge is the next posedge.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t x;
        int   lat;
        wait_idle();
        bus.start_in = 1'b1;
        bus.op_in    = op;
        bus.A        = a;
        bus.B        = b;
        lat = (FAST && is_special(op, a, b)) ? 0 : N;
        ref_model(op, a, b, x.res, x.dbz);
        x.cyc = cyc + 1 + lat;
        x.op  = op;
        x.a   = a;
        x.b   = b;
        exp_q.push_back(x);
        busy_lo = cyc + 1;
        busy_hi = cyc + 1 + lat;
        @(posedge clk) #1;
        bus.start_in = 1'b0;
        bus.op_in    = 2'($urandom);
        bus.A        = $urandom;
        bus.B        = $urandom;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, bus.busy, exp_busy);
            end
            if (bus.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d res=%h", cyc, bus.ALUResult);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ALUResult !== e.res || bus.div_by_zero !== e.dbz || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result op=%0d A=%h B=%h got res=%h dbz=%b cyc=%0d want res=%h dbz=%b cyc=%0d",
                                 e.op, e.a, e.b, bus.ALUResult, bus.div_by_zero, cyc, e.res, e.dbz, e.cyc);
                    end else begin
                        $display("ok op=%0d A=%h B=%h res=%h dbz=%b cyc=%0d",
                                 e.op, e.a, e.b, bus.ALUResult, bus.div_by_zero, cyc);
                    end
                    held_res = e.res;
                    held_dbz = e.dbz;
                end
            end else begin
                checks++;
                if (bus.ALUResult !== held_res || bus.div_by_zero !== held_dbz) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got res=%h dbz=%b want res=%h dbz=%b",
                             cyc, bus.ALUResult, bus.div_by_zero, held_res, held_dbz);
                end
                if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done cyc=%0d want done at cyc=%0d", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]   op;
        logic [N-1:0] a, b;
        bus.start_in = 1'b0;
        bus.op_in    = '0;
        bus.A        = '0;
        bus.B        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        issue(2'd1, 32'd100, 32'd7);
        issue(2'd3, 32'd100, 32'd7);
        issue(2'd0, 32'hFFFF_FFF9, 32'd2);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        issue(2'd1, 32'd5, 32'd0);
        issue(2'd3, 32'd5, 32'd0);
        issue(2'd0, MIN, 32'hFFFF_FFFF);
        issue(2'd2, MIN, 32'hFFFF_FFFF);
        issue(2'd0, 32'd5, 32'd0);
        issue(2'd2, 32'hFFFF_FFF0, 32'd0);

        // Start pulse mid-operation with different operands is ignored.
        issue(2'd1, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.start_in = 1'b1;
        bus.op_in    = 2'd1;
        bus.A        = 32'd9;
        bus.B        = 32'd3;
        @(posedge clk) #1;
        bus.start_in = 1'b0;

        // Start held across the last CALC edge and the DONE edge is ignored too.
        issue(2'd0, 32'd1000, 32'hFFFF_FFFD);
        repeat (N - 2) @(posedge clk);
        #1;
        bus.start_in = 1'b1;
        bus.A        = 32'd77;
        bus.B        = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        bus.start_in = 1'b0;

        // Reset mid-operation aborts with no done pulse.
        issue(2'd1, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        held_res = '0;
        held_dbz = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(2'd1, 32'd100, 32'd7);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       begin a = MIN; b = '1; end
                2:       b = $urandom_range(1, 15);
                3:       b = -$urandom_range(1, 15);
                4:       begin a = $urandom_range(0, 50); b = $urandom_range(1, 60); end
                default: b = $urandom;
            endcase
            issue(op, a, b);
        end

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
